// File: rtl/hfosc_ctrl.sv
// High-speed oscillator power controller: synchronizes per-requester clock demand
// and sequences the oscillator through power-up settle, enable, idle hold and power-down.
module hfosc_ctrl #(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             osc_pu,
    output logic             osc_en,
    output logic             osc_ready,
    output logic [2:0]       state
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        PWRUP = 3'd1,
        ON    = 3'd2,
        HOLD  = 3'd3,
        PWRDN = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic [N_REQ-1:0] req_meta_q, req_sync_q;
    logic            any_req_s;
    logic            pu_q, en_q, rdy_q;
    logic            pu_d, en_d, rdy_d;

    // Two-flop synchronizer for the asynchronous request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= '0;
            req_sync_q <= '0;
        end else begin
            req_meta_q <= req;
            req_sync_q <= req_meta_q;
        end
    end

    assign any_req_s = |req_sync_q;
    // Saturating increment: the counter must never wrap back to a terminal count
    assign cnt_inc_s = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            pu_q    <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pu_q    <= pu_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (any_req_s) begin
                    state_d = PWRUP;
                end else begin
                    state_d = OFF;
                end
            end
            PWRUP: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ON: begin
                cnt_d = '0;
                if (!any_req_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ON;
                end
            end
            HOLD: begin
                if (any_req_s) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = PWRDN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            PWRDN: begin
                cnt_d = '0;
                if (any_req_s) begin
                    state_d = PWRUP;
                end else begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered pins line up with state
    always_comb begin
        pu_d  = 1'b0;
        en_d  = 1'b0;
        rdy_d = 1'b0;
        case (state_d)
            OFF:     begin pu_d = 1'b0; en_d = 1'b0; rdy_d = 1'b0; end
            PWRUP:   begin pu_d = 1'b1; en_d = 1'b0; rdy_d = 1'b0; end
            ON:      begin pu_d = 1'b1; en_d = 1'b1; rdy_d = 1'b1; end
            HOLD:    begin pu_d = 1'b1; en_d = 1'b1; rdy_d = 1'b1; end
            PWRDN:   begin pu_d = 1'b1; en_d = 1'b0; rdy_d = 1'b0; end
            default: begin pu_d = 1'b0; en_d = 1'b0; rdy_d = 1'b0; end
        endcase
    end

    assign osc_pu    = pu_q;
    assign osc_en    = en_q;
    assign osc_ready = rdy_q;
    assign state     = state_q;
    assign gnt       = req_sync_q & {N_REQ{rdy_q}};

endmodule

// File: tb/tb_hfosc_ctrl.sv
// Self-checking bench for hfosc_ctrl: phase/age reference model compared every cycle,
// plus literal checkpoints for the cold-start, hold, re-request and reset scenarios.
module tb_hfosc_ctrl;

    localparam int NR     = 4;
    localparam int SETTLE = 8;
    localparam int HOLDC  = 16;

    localparam int P_OFF = 0, P_PWRUP = 1, P_ON = 2, P_HOLD = 3, P_PWRDN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic          osc_pu, osc_en, osc_ready;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase plus cycles spent in it, and the last two sampled req values
    int          m_phase = P_OFF;
    int          m_age   = 0;
    logic [NR-1:0] m_s1 = '0;
    logic [NR-1:0] m_s2 = '0;

    hfosc_ctrl #(.N_REQ(NR), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLDC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .osc_pu(osc_pu), .osc_en(osc_en), .osc_ready(osc_ready), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic any;
        any = |m_s2;
        case (m_phase)
            P_OFF:   if (any) begin m_phase = P_PWRUP; m_age = 0; end
            P_PWRUP: if (m_age == SETTLE-1) begin m_phase = P_ON; m_age = 0; end
                     else m_age++;
            P_ON:    if (!any) begin m_phase = P_HOLD; m_age = 0; end
            P_HOLD:  if (any) begin m_phase = P_ON; m_age = 0; end
                     else if (m_age == HOLDC-1) begin m_phase = P_PWRDN; m_age = 0; end
                     else m_age++;
            P_PWRDN: begin m_phase = any ? P_PWRUP : P_OFF; m_age = 0; end
            default: m_phase = P_OFF;
        endcase
        m_s2 = m_s1;
        m_s1 = req;
    endtask

    task automatic compare_model();
        bit on_like;
        on_like = (m_phase == P_ON) || (m_phase == P_HOLD);
        check("state",     int'(state),     m_phase);
        check("osc_pu",    int'(osc_pu),    int'(m_phase != P_OFF));
        check("osc_en",    int'(osc_en),    int'(on_like));
        check("osc_ready", int'(osc_ready), int'(on_like));
        check("gnt",       int'(gnt),       on_like ? int'(m_s2) : 0);
        if (osc_en === 1'b0) check("gnt_while_en_low", int'(gnt), 0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_model();
        end
    endtask

    task automatic wait_state(input int st, input string name);
        int budget;
        budget = 200;
        while (state !== 3'(st) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check({name, "_timeout"}, int'(state), st);
    endtask

    task automatic reset_zero_check(input string name);
        check({name, "_state"}, int'(state), 0);
        check({name, "_pu"},    int'(osc_pu), 0);
        check({name, "_en"},    int'(osc_en), 0);
        check({name, "_rdy"},   int'(osc_ready), 0);
        check({name, "_gnt"},   int'(gnt), 0);
    endtask

    initial begin
        // Power-on reset
        #12;
        reset_zero_check("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Cold start: req at cycle 0, PWRUP after 3 edges, ON after 11
        req = 4'b0001;
        tick(2);
        check("cold_off_c2", int'(state), P_OFF);
        tick(1);
        check("cold_pwrup_c3", int'(state), P_PWRUP);
        check("cold_pu_c3", int'(osc_pu), 1);
        tick(7);
        check("cold_en_c10", int'(osc_en), 0);
        tick(1);
        check("cold_on_c11", int'(state), P_ON);
        check("cold_gnt_c11", int'(gnt), 4'b0001);

        // Requester hand-off on different bits must not leave ON
        req = 4'b0010;
        tick(4);
        req = 4'b0100;
        tick(4);
        check("handoff_on", int'(state), P_ON);
        check("handoff_gnt", int'(gnt), 4'b0100);

        // Multi-requester: bit0 drops, bit1 keeps ON
        req = 4'b0011;
        tick(3);
        check("multi_gnt_both", int'(gnt), 4'b0011);
        req = 4'b0010;
        tick(3);
        check("multi_gnt_bit1", int'(gnt), 4'b0010);
        check("multi_still_on", int'(state), P_ON);

        // Idle hold: 16 cycles HOLD, 1 cycle PWRDN, then OFF
        req = 4'b0000;
        tick(3);
        check("hold_entry", int'(state), P_HOLD);
        tick(15);
        check("hold_last", int'(state), P_HOLD);
        tick(1);
        check("pwrdn_state", int'(state), P_PWRDN);
        check("pwrdn_pu", int'(osc_pu), 1);
        check("pwrdn_en", int'(osc_en), 0);
        tick(1);
        check("off_after_pwrdn", int'(state), P_OFF);
        check("off_pu", int'(osc_pu), 0);

        // Re-request in HOLD at count 10
        req = 4'b0001;
        wait_state(P_ON, "rehold_on");
        req = 4'b0000;
        wait_state(P_HOLD, "rehold_hold");
        tick(10);
        req = 4'b0001;
        tick(2);
        check("rehold_gnt", int'(gnt), 4'b0001);
        check("rehold_en", int'(osc_en), 1);
        tick(1);
        check("rehold_back_on", int'(state), P_ON);

        // Re-request landing in PWRDN: back to PWRUP with a full settle
        req = 4'b0000;
        wait_state(P_HOLD, "repd_hold");
        tick(14);
        req = 4'b1000;
        tick(2);
        check("repd_pwrdn", int'(state), P_PWRDN);
        tick(1);
        check("repd_pwrup", int'(state), P_PWRUP);
        tick(7);
        check("repd_settle", int'(state), P_PWRUP);
        tick(1);
        check("repd_on", int'(state), P_ON);
        check("repd_gnt", int'(gnt), 4'b1000);

        // Reset mid-ON: outputs drop asynchronously, no PWRDN step
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        reset_zero_check("rst_mid_on");
        m_phase = P_OFF; m_age = 0; m_s1 = '0; m_s2 = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_off", int'(state), P_OFF);
        tick(1);
        check("post_rst_pwrup", int'(state), P_PWRUP);
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
